// File: rtl/head_sprite_fetch.sv
// Sprite fetch stage for the snake head: scan position -> sprite ROM address,
// with a 3-cycle pipeline to an aligned palette index / valid pair.
module head_sprite_fetch #(
  parameter int SPRITE_W     = 32,
  parameter int SPRITE_H     = 32,
  parameter int ADDR_W       = 10,
  parameter int BLINK_FRAMES = 8
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              vs,
  input  logic [9:0]        Head_X,
  input  logic [9:0]        Head_Y,
  input  logic              blink_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_data,
  output logic [3:0]        pix_index,
  output logic              pix_valid
);
  localparam int XB = $clog2(SPRITE_W);
  localparam int YB = ADDR_W - XB;

  logic [9:0]        pos_x_q, pos_y_q, pos_x_d, pos_y_d;
  logic              vs_q;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic              visible_q, visible_d;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [1:0]        hit_pipe_q;  // [0]=hit_d1, [1]=hit_d2
  logic [3:0]        pix_index_q;
  logic              pix_valid_q;

  logic              vs_fall;
  logic              hit;
  logic [10:0]       x_end, y_end;
  logic [XB-1:0]     rel_x;
  logic [YB-1:0]     rel_y;

  assign vs_fall = vs_q & ~vs;

  // Position and blink state only move on a vsync falling edge, so the
  // sprite cannot tear mid-frame.
  always_comb begin
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    frame_cnt_d = frame_cnt_q;
    visible_d   = visible_q;
    if (vs_fall) begin
      pos_x_d = Head_X;
      pos_y_d = Head_Y;
    end
    if (!blink_en) begin
      frame_cnt_d = '0;
      visible_d   = 1'b1;
    end else if (vs_fall) begin
      if (frame_cnt_q == 8'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = '0;
        visible_d   = ~visible_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
    end
  end

  // 11-bit bounds so a sprite hanging off the right/bottom edge clips
  // instead of wrapping back to column/row 0.
  always_comb begin
    x_end = {1'b0, pos_x_q} + 11'(SPRITE_W);
    y_end = {1'b0, pos_y_q} + 11'(SPRITE_H);
    hit   = (DrawX >= pos_x_q) && ({1'b0, DrawX} < x_end) &&
            (DrawY >= pos_y_q) && ({1'b0, DrawY} < y_end);
    rel_x = XB'(DrawX - pos_x_q);
    rel_y = YB'(DrawY - pos_y_q);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vs_q        <= 1'b1;
      pos_x_q     <= '0;
      pos_y_q     <= '0;
      frame_cnt_q <= '0;
      visible_q   <= 1'b1;
      rom_addr_q  <= '0;
      hit_pipe_q  <= '0;
      pix_index_q <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      vs_q        <= vs;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      frame_cnt_q <= frame_cnt_d;
      visible_q   <= visible_d;
      rom_addr_q  <= hit ? {rel_y, rel_x} : '0;
      hit_pipe_q  <= {hit_pipe_q[0], hit};
      // rom_data here belongs to the address registered two edges ago
      pix_index_q <= hit_pipe_q[1] ? rom_data : 4'd0;
      pix_valid_q <= hit_pipe_q[1] & visible_q & (|rom_data);
    end
  end

  assign rom_addr  = rom_addr_q;
  assign pix_index = pix_index_q;
  assign pix_valid = pix_valid_q;
endmodule

// File: tb/tb_head_sprite_fetch.sv
// Scoreboard bench for head_sprite_fetch: stimulus pushes expected address and
// pixel results; a negedge monitor pops and compares as each result emerges.
module tb_head_sprite_fetch;
  localparam int BF = 2;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic [9:0] DrawX, DrawY, Head_X, Head_Y;
  logic       vs, blink_en;
  logic [9:0] rom_addr;
  logic [3:0] rom_data = 4'd0;
  logic [3:0] pix_index;
  logic       pix_valid;

  head_sprite_fetch #(.SPRITE_W(32), .SPRITE_H(32), .ADDR_W(10), .BLINK_FRAMES(BF)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY), .vs(vs),
    .Head_X(Head_X), .Head_Y(Head_Y), .blink_en(blink_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .pix_index(pix_index), .pix_valid(pix_valid)
  );

  always #5 Clk = ~Clk;

  function automatic logic [3:0] rom_f(input logic [9:0] a);
    return a[3:0] + a[7:4] + {2'b00, a[9:8]};
  endfunction

  // Synchronous sprite ROM model
  always @(posedge Clk) rom_data <= rom_f(rom_addr);

  int n_vec = 0;
  int n_err = 0;

  logic [9:0] aq[$];
  logic [4:0] eq[$];
  logic       issue = 1'b0;
  logic [2:0] iss;

  int  m_px = 0, m_py = 0, m_cnt = 0;
  bit  m_vis = 1'b1;

  always @(posedge Clk or negedge Reset_n)
    if (!Reset_n) iss <= 3'b000;
    else          iss <= {iss[1:0], issue};

  always @(negedge Clk) begin
    if (Reset_n === 1'b1) begin
      if (iss[0]) begin
        n_vec++;
        if (aq.size() == 0) begin
          n_err++;
          $display("FAIL addr_queue: empty when rom_addr=%0d emerged", rom_addr);
        end else begin
          logic [9:0] ea;
          ea = aq.pop_front();
          if (rom_addr !== ea) begin
            n_err++;
            $display("FAIL rom_addr: got %0d expected %0d (t=%0t)", rom_addr, ea, $time);
          end
        end
      end
      if (iss[2]) begin
        n_vec++;
        if (eq.size() == 0) begin
          n_err++;
          $display("FAIL pix_queue: empty when pixel emerged");
        end else begin
          logic [4:0] ep;
          ep = eq.pop_front();
          if ({pix_valid, pix_index} !== ep) begin
            n_err++;
            $display("FAIL pixel: got valid=%0b index=%0d expected valid=%0b index=%0d (t=%0t)",
                     pix_valid, pix_index, ep[4], ep[3:0], $time);
          end
        end
      end
    end
  end

  task automatic check_now(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // One clock cycle of stimulus; optionally issue a pixel and/or a vs fall.
  task automatic step(input bit iss_px, input int x, input int y, input bit fall);
    DrawX = 10'(x);
    DrawY = 10'(y);
    vs    = fall ? 1'b0 : 1'b1;
    issue = iss_px;
    if (iss_px) begin
      bit hit;
      int addr;
      logic [3:0] idx;
      hit  = (x >= m_px) && (x < m_px + 32) && (y >= m_py) && (y < m_py + 32);
      addr = hit ? ((y - m_py) * 32 + (x - m_px)) : 0;
      idx  = hit ? rom_f(10'(addr)) : 4'd0;
      aq.push_back(10'(addr));
      eq.push_back({hit && m_vis && (idx != 4'd0), idx});
    end
    @(posedge Clk);
    if (fall) begin
      m_px = Head_X;
      m_py = Head_Y;
      if (blink_en) begin
        if (m_cnt == BF - 1) begin m_cnt = 0; m_vis = !m_vis; end
        else m_cnt++;
      end
    end
    if (!blink_en) begin m_cnt = 0; m_vis = 1'b1; end
    #1;
    issue = 1'b0;
    vs    = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0);
  endtask

  task automatic vsfall();
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
  endtask

  initial begin
    Reset_n = 1'b0; vs = 1'b1; blink_en = 1'b0;
    DrawX = '0; DrawY = '0; Head_X = 10'd100; Head_Y = 10'd50;
    #12;
    check_now("reset_rom_addr", 32'(rom_addr), 0);
    check_now("reset_pix_index", 32'(pix_index), 0);
    check_now("reset_pix_valid", 32'(pix_valid), 0);
    #5 Reset_n = 1'b1;
    @(posedge Clk); #1;

    // Position is 0,0 after reset; Head inputs ignored until a vs fall
    step(1, 0, 0, 0);
    step(1, 5, 3, 0);
    step(1, 100, 50, 0);
    idle(4);

    // Latch (100,50), scan the sprite's first row plus both neighbours
    vsfall();
    for (int x = 99; x <= 132; x++) step(1, x, 50, 0);
    step(1, 100, 51, 0);
    step(1, 131, 81, 0);
    step(1, 131, 82, 0);
    step(1, 100, 49, 0);
    idle(4);

    // Mid-frame head change is ignored; vs fall with a hit uses old position
    Head_X = 10'd200; Head_Y = 10'd60;
    step(1, 100, 50, 0);
    step(1, 101, 50, 1);
    step(1, 101, 50, 0);
    step(1, 201, 60, 0);
    idle(4);

    // Right-edge clip, including transparent (addr 0) and index-3 pixels
    Head_X = 10'd630; Head_Y = 10'd10;
    vsfall();
    for (int x = 628; x <= 639; x++) step(1, x, 10, 0);
    step(1, 0, 10, 0);
    step(1, 630, 41, 0);
    idle(4);

    // Bottom-edge clip, no wrap to row 0
    Head_X = 10'd0; Head_Y = 10'd470;
    vsfall();
    step(1, 5, 479, 0);
    step(1, 5, 0, 0);
    step(1, 0, 469, 0);
    idle(4);

    // Blink with BLINK_FRAMES=2
    Head_X = 10'd100; Head_Y = 10'd50;
    blink_en = 1'b1;
    for (int f = 1; f <= 6; f++) begin
      vsfall();
      for (int x = 101; x <= 104; x++) step(1, x, 50, 0);
      idle(4);
    end
    blink_en = 1'b0;
    idle(1);
    for (int x = 101; x <= 104; x++) step(1, x, 50, 0);
    idle(4);

    // Asynchronous reset with pixels in flight
    for (int x = 105; x <= 110; x++) step(1, x, 50, 0);
    #1 Reset_n = 1'b0;
    #1;
    check_now("midreset_rom_addr", 32'(rom_addr), 0);
    check_now("midreset_pix_index", 32'(pix_index), 0);
    check_now("midreset_pix_valid", 32'(pix_valid), 0);
    aq.delete(); eq.delete();
    m_px = 0; m_py = 0; m_cnt = 0; m_vis = 1'b1;
    @(posedge Clk); @(posedge Clk); #1;
    Reset_n = 1'b1;
    @(posedge Clk); #1;
    step(1, 0, 0, 0);
    step(1, 3, 0, 0);
    step(1, 100, 50, 0);
    idle(5);

    n_vec++;
    if (aq.size() != 0 || eq.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d addr and %0d pixel entries left, expected 0", aq.size(), eq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/head_sprite_fetch.md
# head_sprite_fetch

Per-pixel sprite fetch stage that sits directly upstream of the snake-head palette lookup. From the VGA scan position (DrawX/DrawY) and the head's top-left screen position, it computes the sprite ROM address and drives a synchronous ROM. It returns the 4-bit palette index, aligned with a hit/valid flag, three cycles later. Head position is latched once per frame so the sprite never tears mid-frame. An optional blink mode hides the sprite on alternate blink periods.

## Interface
Parameters:
- SPRITE_W, 32, sprite width in pixels; must be a power of two
- SPRITE_H, 32, sprite height in pixels
- ADDR_W, 10, ROM address width; equals log2(SPRITE_W*SPRITE_H)
- BLINK_FRAMES, 8, frames per blink half-period; range 1–255

Ports:
- Clk  in  1  pixel clock; everything is rising-edge
- Reset_n  in  1  reset; asynchronous assert, active-low
- DrawX  in  10  current scan column, 0–639
- DrawY  in  10  current scan row, 0–479
- vs  in  1  VGA vertical sync, active-low
- Head_X  in  10  requested head top-left column
- Head_Y  in  10  requested head top-left row
- blink_en  in  1  enables blinking
- rom_addr  out  ADDR_W  address to the synchronous sprite ROM
- rom_data  in  4  ROM output; valid one cycle after rom_addr is sampled
- pix_index  out  4  palette index for the palette stage
- pix_valid  out  1  sprite pixel is present and non-transparent

## Operation
- Clock is Clk. Reset is asynchronous and active-low on Reset_n.
- Reset values:
  - pos_x = pos_y = 0, vs_d = 1
  - frame_cnt = 0, visible = 1
  - rom_addr = 0, hit pipeline = 0
  - pix_index = 0, pix_valid = 0
- Frame latch: vs_d registers vs. A falling edge is vs_d=1 and vs=0. On a falling edge:
  - pos_x ← Head_X, pos_y ← Head_Y
  - frame_cnt increments
  - when frame_cnt reaches BLINK_FRAMES−1, it wraps to 0 and visible toggles
  - Head_X/Head_Y changes at any other time have no effect
- Blink: while blink_en=0, visible is forced to 1 and frame_cnt holds 0. If blink_en deasserts, visible returns to 1 on the next cycle.
- Hit test uses 11-bit arithmetic so there is no overflow at the right or bottom screen edge:
  - hit = (DrawX ≥ pos_x) & ({1'b0,DrawX} < pos_x+SPRITE_W) & (DrawY ≥ pos_y) & ({1'b0,DrawY} < pos_y+SPRITE_H)
  - A sprite partially off-screen (e.g. pos_x=630) produces hits only for DrawX 630–639. There is no wrap to column 0.
- Address: rel_x = DrawX−pos_x and rel_y = DrawY−pos_y, truncated.
  - rom_addr = rel_y*SPRITE_W + rel_x, implemented as concatenation {rel_y, rel_x[log2(SPRITE_W)-1:0]}.
  - On a miss, rom_addr is driven to 0.
- Output:
  - pix_valid = hit_d2 & visible & (rom_data ≠ 0)
  - pix_index = rom_data when hit_d2, else 0
  - Index 0 (magenta) is the transparent key.

## Timing
- Stage 0, cycle k: DrawX/DrawY are presented and combinational hit/address are formed.
- Edge k+1: rom_addr and hit_d1 are registered.
- Edge k+2: the ROM samples rom_addr and hit_d2 ← hit_d1.
- Edge k+3: pix_index and pix_valid are registered. Fixed latency is 3 cycles; the downstream color mapper delays its DrawX/blank by 3.
- Fully pipelined: one pixel per cycle, no stalls, no backpressure.
- Reset mid-frame clears the pipeline immediately. Outputs are 0 until the first pixel enters after Reset_n rises (3 cycles). The position stays 0,0 until the next vs falling edge.
- A vs edge and a hit in the same cycle: that pixel uses the old pos_x/pos_y, and the new position applies from the next cycle.
- visible is sampled at the output stage, so a toggle takes effect on the pixel exiting in that cycle.

## Test plan
- Reset with Reset_n=0 mid-stream → all outputs 0 asynchronously. After release, pos=0,0, and DrawX=0/DrawY=0 yields rom_addr=0 one cycle later.
- Latch Head=(100,50) at a vs fall, then scan DrawX=100..131 on DrawY=50.
  - rom_addr = 0..31 one cycle after each input
  - pix_index matches the ROM model 3 cycles after each input
  - DrawX=99 and DrawX=132 give pix_valid=0
- Change Head_X mid-frame → no change until the next vs fall. A vs fall coinciding with a hit pixel uses the old position for that pixel.
- Right-edge clip at pos_x=630: DrawX 630–639 hit with rel_x 0–9. DrawX=0 does not hit.
- Transparency: rom_data=0 inside the sprite → pix_valid=0, pix_index=0. rom_data=4'h3 → pix_valid=1, pix_index=3.
- Blink with blink_en=1 and BLINK_FRAMES=2 → pix_valid is suppressed on frames 2–3, restored on 4–5. Deasserting blink_en restores visible=1 next cycle.
